if_id_queue: RTL and testbench

Parametrised successor to the single-entry IF/ID pipeline register. It is a DEPTH-entry instruction queue between fetch and decode, with a valid/ready handshake on both sides. A single-cycle flush kills every queued entry and the entry being presented by fetch in the same cycle. The decode side sees the head entry already split into RISC-V fields, zero-masked as a bubble whenever the queue is empty.

---
 rtl/if_id_pkg.sv | 42 ++++
 rtl/if_id_fifo_core.sv | 56 +++++
 rtl/if_id_queue.sv | 78 +++++++
 tb/tb_if_id_queue.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/if_id_pkg.sv
// rtl/if_id_pkg.sv - shared RV32 field layout, bubble constant and fetch beat type
package if_id_pkg;
  localparam int OPC_LSB = 0;
  localparam int OPC_MSB = 6;
  localparam int RD_LSB  = 7;
  localparam int RD_MSB  = 11;
  localparam int F3_LSB  = 12;
  localparam int F3_MSB  = 14;
  localparam int RS1_LSB = 15;
  localparam int RS1_MSB = 19;
  localparam int RS2_LSB = 20;
  localparam int RS2_MSB = 24;
  localparam int F7_LSB  = 25;
  localparam int F7_MSB  = 31;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } id_fields_t;

  localparam id_fields_t ID_BUBBLE = '0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_beat_t;

  function automatic id_fields_t split_inst(input logic [31:0] inst);
    id_fields_t f;
    f.opcode = inst[OPC_MSB:OPC_LSB];
    f.rd     = inst[RD_MSB:RD_LSB];
    f.funct3 = inst[F3_MSB:F3_LSB];
    f.rs1    = inst[RS1_MSB:RS1_LSB];
    f.rs2    = inst[RS2_MSB:RS2_LSB];
    f.funct7 = inst[F7_MSB:F7_LSB];
    return f;
  endfunction
endpackage

// File: rtl/if_id_fifo_core.sv
// rtl/if_id_fifo_core.sv - DEPTH x W circular buffer with pointers, occupancy count and flush-clear
module if_id_fifo_core #(
  parameter int W     = 64,
  parameter int DEPTH = 2,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic [CW-1:0] count
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Flush wins over any write/read issued in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(wr_en) - CW'(rd_en);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !flush) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;
endmodule

// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - fetch-to-decode instruction queue with handshake and bubble-masked RV32 fields
module if_id_queue
  import if_id_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int ILEN  = 32,
  parameter int DEPTH = 2,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [XLEN-1:0] if_pc,
  input  logic [ILEN-1:0] if_inst,
  input  logic            flush,
  input  logic            id_ready,
  output logic            id_valid,
  output logic [XLEN-1:0] pc_id,
  output logic [31:0]     inst_imm,
  output logic [6:0]      opcode,
  output logic [4:0]      wR,
  output logic [2:0]      funct3,
  output logic [4:0]      rR1,
  output logic [4:0]      rR2,
  output logic [6:0]      funct7,
  output logic [CW-1:0]   count
);
  logic                 enq, deq;
  logic [XLEN+ILEN-1:0] head;
  logic [XLEN-1:0]      head_pc;
  logic [ILEN-1:0]      head_inst;
  id_fields_t           fields;

  // Ready/valid derive from the registered count only, so no input reaches them combinationally.
  assign if_ready = (count != CW'(DEPTH));
  assign id_valid = (count != '0);

  always_comb begin
    enq = if_valid & if_ready & ~flush;
    deq = id_valid & id_ready & ~flush;
  end

  if_id_fifo_core #(
    .W     (XLEN + ILEN),
    .DEPTH (DEPTH)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .wr_en   (enq),
    .wr_data ({if_pc, if_inst}),
    .rd_en   (deq),
    .rd_data (head),
    .count   (count)
  );

  assign head_pc   = head[XLEN+ILEN-1:ILEN];
  assign head_inst = head[ILEN-1:0];

  always_comb begin
    fields   = ID_BUBBLE;
    pc_id    = '0;
    inst_imm = '0;
    if (id_valid) begin
      fields   = split_inst(head_inst);
      pc_id    = head_pc;
      inst_imm = head_inst;
    end
  end

  assign opcode = fields.opcode;
  assign wR     = fields.rd;
  assign funct3 = fields.funct3;
  assign rR1    = fields.rs1;
  assign rR2    = fields.rs2;
  assign funct7 = fields.funct7;
endmodule

// File: tb/tb_if_id_queue.sv
// tb/tb_if_id_queue.sv - self-checking bench for if_id_queue against a queue reference model
module tb_if_id_queue;
  import if_id_pkg::*;

  localparam int XLEN  = 32;
  localparam int ILEN  = 32;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            if_valid = 1'b0;
  logic            if_ready;
  logic [XLEN-1:0] if_pc = '0;
  logic [ILEN-1:0] if_inst = '0;
  logic            flush = 1'b0;
  logic            id_ready = 1'b0;
  logic            id_valid;
  logic [XLEN-1:0] pc_id;
  logic [31:0]     inst_imm;
  logic [6:0]      opcode;
  logic [4:0]      wR;
  logic [2:0]      funct3;
  logic [4:0]      rR1;
  logic [4:0]      rR2;
  logic [6:0]      funct7;
  logic [CW-1:0]   count;

  int total = 0;
  int bad = 0;
  fetch_beat_t model_q[$];

  if_id_queue #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(if_ready),
    .if_pc(if_pc), .if_inst(if_inst), .flush(flush), .id_ready(id_ready),
    .id_valid(id_valid), .pc_id(pc_id), .inst_imm(inst_imm), .opcode(opcode),
    .wR(wR), .funct3(funct3), .rR1(rR1), .rR2(rR2), .funct7(funct7), .count(count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    total++;
    assert (int'(count) <= DEPTH && id_valid == (count != 0) && if_ready == (int'(count) != DEPTH))
    else begin
      bad++;
      $display("FAIL invariant count=%0d id_valid=%0b if_ready=%0b", count, id_valid, if_ready);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; if_valid = 0; flush = 0; id_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL reset_id_valid got=%0b exp=0", id_valid); end
    total++; if (if_ready !== 1'b1) begin bad++; $display("FAIL reset_if_ready got=%0b exp=1", if_ready); end
    total++; if (count !== '0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if ({pc_id, inst_imm, opcode, wR, funct3, rR1, rR2, funct7} !== '0) begin
      bad++; $display("FAIL reset_fields pc=%h inst=%h exp all zero", pc_id, inst_imm);
    end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_single;
    if_valid = 1; if_pc = 32'h0; if_inst = 32'h00500093; id_ready = 1;
    tick;
    if_valid = 0;
    total++; if (id_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%0b exp=1", id_valid); end
    total++; if (opcode !== 7'h13) begin bad++; $display("FAIL single_opcode got=%h exp=13", opcode); end
    total++; if (wR !== 5'd1) begin bad++; $display("FAIL single_wR got=%0d exp=1", wR); end
    total++; if (rR1 !== 5'd0 || funct3 !== 3'd0) begin bad++; $display("FAIL single_rs1_f3 got=%0d/%0d exp=0/0", rR1, funct3); end
    total++; if (rR2 !== 5'd5 || funct7 !== 7'd0) begin bad++; $display("FAIL single_rs2_f7 got=%0d/%0d exp=5/0", rR2, funct7); end
    total++; if (inst_imm !== 32'h00500093) begin bad++; $display("FAIL single_inst got=%h exp=00500093", inst_imm); end
    total++; if (count !== CW'(1)) begin bad++; $display("FAIL single_count got=%0d exp=1", count); end
    tick;
    total++; if (count !== '0 || id_valid !== 1'b0) begin bad++; $display("FAIL single_drain count=%0d valid=%0b exp=0/0", count, id_valid); end
    total++; if ({inst_imm, opcode, wR} !== '0) begin bad++; $display("FAIL single_bubble inst=%h exp=0", inst_imm); end
  endtask

  task automatic test_fill_stall;
    id_ready = 0; if_valid = 1; if_pc = 32'h0; if_inst = 32'h00000013;
    tick;
    total++; if (count !== CW'(1) || if_ready !== 1'b1) begin bad++; $display("FAIL fill1 count=%0d ready=%0b exp=1/1", count, if_ready); end
    if_pc = 32'h4; if_inst = 32'h00100113;
    tick;
    total++; if (count !== CW'(2) || if_ready !== 1'b0) begin bad++; $display("FAIL fill2 count=%0d ready=%0b exp=2/0", count, if_ready); end
    if_pc = 32'h8; if_inst = 32'h00200193;
    repeat (3) begin
      tick;
      total++; if (count !== CW'(2) || pc_id !== 32'h0 || inst_imm !== 32'h00000013) begin
        bad++; $display("FAIL stall_hold count=%0d pc=%h inst=%h exp=2/0/00000013", count, pc_id, inst_imm);
      end
    end
    id_ready = 1;
    tick;
    total++; if (count !== CW'(1) || pc_id !== 32'h4) begin bad++; $display("FAIL pop0 count=%0d pc=%h exp=1/4", count, pc_id); end
    tick;
    total++; if (count !== CW'(1) || pc_id !== 32'h8 || inst_imm !== 32'h00200193) begin
      bad++; $display("FAIL pop4_push8 count=%0d pc=%h exp=1/8", count, pc_id);
    end
    if_valid = 0;
    tick;
    total++; if (count !== '0) begin bad++; $display("FAIL fill_drain count=%0d exp=0", count); end
  endtask

  task automatic test_flush;
    id_ready = 0; if_valid = 1; if_pc = 32'h20; if_inst = $urandom;
    tick;
    if_pc = 32'h24; if_inst = $urandom;
    tick;
    total++; if (count !== CW'(2)) begin bad++; $display("FAIL flush_pre count=%0d exp=2", count); end
    if_pc = 32'h28; id_ready = 1; flush = 1;
    tick;
    flush = 0; if_valid = 0; id_ready = 0;
    total++; if (count !== '0 || id_valid !== 1'b0 || pc_id !== '0 || if_ready !== 1'b1) begin
      bad++; $display("FAIL flush_clear count=%0d valid=%0b pc=%h ready=%0b exp=0/0/0/1", count, id_valid, pc_id, if_ready);
    end
    flush = 1; if_valid = 1; id_ready = 1;
    for (int i = 0; i < 3; i++) begin
      tick;
      total++; if (count !== '0) begin bad++; $display("FAIL flush_hold%0d count=%0d exp=0", i, count); end
    end
    flush = 0; id_ready = 0; if_pc = 32'h30; if_inst = 32'h00300213;
    tick;
    if_valid = 0;
    total++; if (count !== CW'(1) || pc_id !== 32'h30 || inst_imm !== 32'h00300213) begin
      bad++; $display("FAIL flush_after count=%0d pc=%h exp=1/30", count, pc_id);
    end
    id_ready = 1;
    tick;
  endtask

  task automatic test_stream;
    logic [31:0] inst_v;
    id_ready = 1;
    for (int i = 0; i < 10; i++) begin
      inst_v = $urandom;
      if_valid = 1; if_pc = 32'h100 + 32'(4 * i); if_inst = inst_v;
      tick;
      total++; if (count !== CW'(1) || pc_id !== 32'h100 + 32'(4 * i) || inst_imm !== inst_v) begin
        bad++; $display("FAIL stream%0d count=%0d pc=%h inst=%h exp=1/%h/%h", i, count, pc_id, inst_imm, 32'h100 + 32'(4 * i), inst_v);
      end
    end
    if_valid = 0;
    tick;
    total++; if (count !== '0) begin bad++; $display("FAIL stream_drain count=%0d exp=0", count); end
  endtask

  task automatic test_random;
    logic [31:0] pc_n, hi;
    logic        hold, vld, fl, rdy, acc, ev;
    int          sz;
    fetch_beat_t hd;
    pc_n = 32'h1000; hold = 0; vld = 0;
    model_q.delete();
    for (int c = 0; c < 10000; c++) begin
      if (!hold) begin
        vld = ($urandom_range(0, 9) < 7);
        if_pc = pc_n; if_inst = $urandom;
      end
      fl  = ($urandom_range(0, 31) == 0);
      rdy = ($urandom_range(0, 9) < 6);
      if_valid = vld; flush = fl; id_ready = rdy;
      sz = model_q.size();
      ev = (sz != 0);
      hd = ev ? model_q[0] : '0;
      hi = hd.inst;
      total++; if (id_valid !== ev || int'(count) != sz || if_ready !== (sz != DEPTH)) begin
        bad++; if (bad < 20) $display("FAIL rnd_state c=%0d valid=%0b count=%0d ready=%0b exp_size=%0d", c, id_valid, count, if_ready, sz);
      end
      total++; if (pc_id !== hd.pc || inst_imm !== hi) begin
        bad++; if (bad < 20) $display("FAIL rnd_head c=%0d pc=%h inst=%h exp=%h/%h", c, pc_id, inst_imm, hd.pc, hi);
      end
      total++; if ({opcode, wR, funct3, rR1, rR2, funct7} !==
                   {7'(hi), 5'(hi >> 7), 3'(hi >> 12), 5'(hi >> 15), 5'(hi >> 20), 7'(hi >> 25)}) begin
        bad++; if (bad < 20) $display("FAIL rnd_fields c=%0d op=%h rd=%0d f3=%0d exp_inst=%h", c, opcode, wR, funct3, hi);
      end
      acc = vld && (sz < DEPTH) && !fl;
      if (fl) model_q.delete();
      else begin
        if (rdy && sz != 0) void'(model_q.pop_front());
        if (acc) model_q.push_back('{pc: if_pc, inst: if_inst});
      end
      hold = vld && !acc && !fl;
      if (vld && !hold) pc_n = pc_n + 32'h4;
      tick;
    end
    if_valid = 0; flush = 1;
    tick;
    flush = 0;
    model_q.delete();
  endtask

  task automatic test_async_reset;
    id_ready = 0; if_valid = 1; if_pc = 32'h40; if_inst = $urandom;
    tick;
    if_pc = 32'h44;
    tick;
    if_pc = 32'h48;
    tick;
    total++; if (count !== CW'(2)) begin bad++; $display("FAIL arst_pre count=%0d exp=2", count); end
    #2 rst_n = 0;
    #1;
    total++; if (count !== '0 || id_valid !== 1'b0 || if_ready !== 1'b1) begin
      bad++; $display("FAIL arst_now count=%0d valid=%0b ready=%0b exp=0/0/1", count, id_valid, if_ready);
    end
    total++; if ({pc_id, inst_imm, opcode, funct7} !== '0) begin bad++; $display("FAIL arst_fields pc=%h inst=%h exp=0", pc_id, inst_imm); end
    tick;
    rst_n = 1; if_valid = 0;
    tick;
    total++; if (count !== '0) begin bad++; $display("FAIL arst_after count=%0d exp=0", count); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_fill_stall;
    test_flush;
    test_stream;
    test_random;
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
